id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- Decode-to-execute pipeline register for the 5-stage RISC-V core.
- Captures the decode-stage control bundle produced by the controller, plus the register-file operands, immediate, PC values and register indices.
- Presents them as execute-stage (E) signals one cycle later.
- Supports stall (hold), flush (bubble insertion) and tracks instruction validity for the hazard unit.

Parameters:
- XLEN, 32, datapath width of operands, immediate and PC
- CNT_W, 16, width of the optional bubble counter

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low
- enE  in  1  load enable; 0 holds the current contents (stall)
- clrE  in  1  flush; loads a bubble
- validD  in  1  decode slot holds a real instruction
- regWriteD  in  1  register-file write enable
- resultSrcD  in  2  writeback mux select
- memWriteD  in  1  data-memory write enable
- jumpD  in  2  jump type (jal/jalr)
- branchD  in  3  branch condition code
- ALUControlD  in  3  ALU operation
- ALUSrcD  in  1  ALU operand-B select
- luiD  in  1  LUI pass-through select
- RD1D, RD2D  in  XLEN  register-file read data
- extImmD  in  XLEN  sign-extended immediate
- PCD, PCPlus4D  in  XLEN  instruction PC and PC+4
- rs1D, rs2D, rdD  in  5  register indices
- validE  out  1  execute slot holds a real instruction
- regWriteE, resultSrcE, memWriteE, jumpE, branchE, ALUControlE, ALUSrcE, luiE  out  same widths as D  registered control
- RD1E, RD2E, extImmE, PCE, PCPlus4E  out  XLEN  registered data
- rs1E, rs2E, rdE  out  5  registered indices
- bubbleCntE  out  CNT_W  flush counter (see Optional Feature)

Behaviour:
- All outputs are registered; latency is 1 cycle from D inputs to E outputs.
- No combinational path from input to output.
- Priority at each rising edge: rst==0 > clrE==1 > enE==0 > load.
- Reset (rst==0 at an edge): every output is cleared to 0, including validE and bubbleCntE.
- Reset mid-stall or mid-flush: reset wins and the register is empty next cycle.
- Flush (clrE==1): loads a bubble.
  - All control outputs = 0, so a bubble never writes the register file or memory, never branches or jumps.
  - validE = 0.
  - rdE, rs1E, rs2E = 0, so no forwarding matches.
  - Data fields = 0.
  - Flush overrides enE==0: a simultaneous stall and flush yields a bubble. This is the load-use case (stallD plus flushE).
- Hold (enE==0, clrE==0): all outputs keep their previous values, including validE.
- Load (enE==1, clrE==0): every E output takes its D input, with these exceptions:
  - regWriteE = regWriteD & (rdD != 0). Writes to x0 are dropped here, which keeps forwarding logic free of an x0 check.
  - validD==0: the word is loaded as a bubble, identical to the flush case.
- Back-to-back flushes produce consecutive bubbles; the register has no internal state beyond its outputs.
- X on D inputs during flush or reset must not propagate to any output.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN
- Defined:
  - bubbleCntE increments by 1 on every non-reset edge where a bubble is loaded (clrE==1, or load with validD==0).
  - It saturates at 2^CNT_W-1, with no wrap.
  - It is not affected by enE.
  - Reset clears it to 0.
- Undefined: bubbleCntE is tied to constant 0 and the counter flops are not built.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - XLEN_DEF = 32 and REG_IDX_W = 5
  - Field widths RESULT_SRC_W = 2, JUMP_W = 2, BRANCH_W = 3, ALU_CTRL_W = 3
  - A packed ctrl_bundle_t typedef containing regWrite, resultSrc, memWrite, jump, branch, ALUControl, ALUSrc and lui.
  - Its zero constant CTRL_BUBBLE.
- One sub-module is natural: pipe_reg_en_clr.
  - Parameterised width W.
  - Synchronous active-low reset, clear, enable.
  - Instantiated once for the control bundle plus validE, and once for the data and index fields.
  - The regWrite x0 gating and the counter stay in the top.

Test Plan:
- Reset: rst=0 for 2 cycles with all D inputs at 1 -> every output is 0 and validE=0. Release -> the first load appears 1 cycle later.
- Load: validD=1, regWriteD=1, rdD=5, RD1D=32'h0000_1234, ALUControlD=3'b010, enE=1 -> next cycle regWriteE=1, rdE=5, RD1E=32'h0000_1234, ALUControlE=3'b010, validE=1.
- x0 drop: regWriteD=1, rdD=0 -> regWriteE=0; all other fields load normally.
- Stall: load PCD=32'h100, then set enE=0 for 3 cycles while PCD changes to 32'h104 -> PCE stays 32'h100 for all 3 cycles. Set enE=1 -> PCE=32'h104.
- Flush over stall: enE=0, clrE=1, memWriteD=1, rdD=7 -> memWriteE=0, rdE=0, validE=0. With ID_EX_BUBBLE_CNT_EN defined, bubbleCntE goes 0->1.
- Counter saturation: CNT_W=2, apply 5 consecutive flushes -> bubbleCntE goes 1,2,3,3,3. Undefined build -> bubbleCntE=0 throughout.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pipe_pkg
// Shared definitions for the 5-stage RISC-V pipeline registers:
//   - default datapath width and register-index width
//   - widths of the encoded control fields
//   - ctrl_bundle_t : packed decode-stage control bundle
//   - CTRL_BUBBLE   : all-zero bundle used for bubbles
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pipe_pkg;

   localparam int XLEN_DEF     = 32;
   localparam int REG_IDX_W    = 5;
   localparam int RESULT_SRC_W = 2;
   localparam int JUMP_W       = 2;
   localparam int BRANCH_W     = 3;
   localparam int ALU_CTRL_W   = 3;

   typedef struct packed {
      logic                    regWrite;
      logic [RESULT_SRC_W-1:0] resultSrc;
      logic                    memWrite;
      logic [JUMP_W-1:0]       jump;
      logic [BRANCH_W-1:0]     branch;
      logic [ALU_CTRL_W-1:0]   ALUControl;
      logic                    ALUSrc;
      logic                    lui;
   } ctrl_bundle_t;

   localparam ctrl_bundle_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Bundles the decode-side (D) inputs, the enable/flush controls and the
// execute-side (E) outputs of the ID/EX pipeline register.
//   modport master : drives D signals, enE, clrE; observes E signals
//   modport slave  : the pipeline register itself
// Parameters: XLEN (datapath width), CNT_W (bubble counter width).
// -----------------------------------------------------------------------------
interface id_ex_pipe_reg_if
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 16
);

   logic                    enE;
   logic                    clrE;

   logic                    validD;
   logic                    regWriteD;
   logic [RESULT_SRC_W-1:0] resultSrcD;
   logic                    memWriteD;
   logic [JUMP_W-1:0]       jumpD;
   logic [BRANCH_W-1:0]     branchD;
   logic [ALU_CTRL_W-1:0]   ALUControlD;
   logic                    ALUSrcD;
   logic                    luiD;
   logic [XLEN-1:0]         RD1D, RD2D, extImmD, PCD, PCPlus4D;
   logic [REG_IDX_W-1:0]    rs1D, rs2D, rdD;

   logic                    validE;
   logic                    regWriteE;
   logic [RESULT_SRC_W-1:0] resultSrcE;
   logic                    memWriteE;
   logic [JUMP_W-1:0]       jumpE;
   logic [BRANCH_W-1:0]     branchE;
   logic [ALU_CTRL_W-1:0]   ALUControlE;
   logic                    ALUSrcE;
   logic                    luiE;
   logic [XLEN-1:0]         RD1E, RD2E, extImmE, PCE, PCPlus4E;
   logic [REG_IDX_W-1:0]    rs1E, rs2E, rdE;
   logic [CNT_W-1:0]        bubbleCntE;

   modport master (
      output enE, clrE, validD, regWriteD, resultSrcD, memWriteD, jumpD,
             branchD, ALUControlD, ALUSrcD, luiD, RD1D, RD2D, extImmD, PCD,
             PCPlus4D, rs1D, rs2D, rdD,
      input  validE, regWriteE, resultSrcE, memWriteE, jumpE, branchE,
             ALUControlE, ALUSrcE, luiE, RD1E, RD2E, extImmE, PCE, PCPlus4E,
             rs1E, rs2E, rdE, bubbleCntE
   );

   modport slave (
      input  enE, clrE, validD, regWriteD, resultSrcD, memWriteD, jumpD,
             branchD, ALUControlD, ALUSrcD, luiD, RD1D, RD2D, extImmD, PCD,
             PCPlus4D, rs1D, rs2D, rdD,
      output validE, regWriteE, resultSrcE, memWriteE, jumpE, branchE,
             ALUControlE, ALUSrcE, luiE, RD1E, RD2E, extImmE, PCE, PCPlus4E,
             rs1E, rs2E, rdE, bubbleCntE
   );

endinterface

// File: rtl/pipe_reg_en_clr.sv
// -----------------------------------------------------------------------------
// pipe_reg_en_clr
// Generic W-bit pipeline register with priority reset > clear > enable.
//   clk : clock (rising edge)
//   rst : synchronous reset, active-low, clears q
//   clr : synchronous clear, loads zero
//   en  : load enable, 0 holds q
//   d   : data in
//   q   : registered data out
// -----------------------------------------------------------------------------
module pipe_reg_en_clr #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   // Clear loads a constant so X on d never reaches q during a bubble.
   always_ff @(posedge clk) begin
      if (!rst)
         q_reg <= '0;
      else if (clr)
         q_reg <= '0;
      else if (en)
         q_reg <= d;
   end

   assign q = q_reg;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register of the 5-stage RISC-V core.
//   clk : core clock
//   rst : synchronous reset, active-low
//   bus : id_ex_pipe_reg_if.slave -- D inputs, enE (stall when 0),
//         clrE (flush), E outputs and bubbleCntE
// Optional build macro: ID_EX_BUBBLE_CNT_EN -- when defined, bubbleCntE counts
// loaded bubbles (saturating); otherwise it is constant 0.
// -----------------------------------------------------------------------------
module id_ex_pipe_reg
   import riscv_pipe_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   id_ex_pipe_reg_if.slave    bus
);

   localparam int CTRL_W = $bits(ctrl_bundle_t);
   localparam int DATA_W = 5 * XLEN + 3 * REG_IDX_W;

   ctrl_bundle_t      ctrl_d;
   ctrl_bundle_t      ctrl_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_d;
   logic [DATA_W-1:0] data_q;
   logic              bubble_load;

   // An invalid decode slot is loaded exactly like a flush; during a stall
   // (enE=0) nothing is loaded, so validD is ignored then.
   assign bubble_load = bus.clrE | (bus.enE & ~bus.validD);

   // Writes to x0 are dropped here so forwarding needs no x0 comparison.
   assign ctrl_d = '{
      regWrite:   bus.regWriteD & (bus.rdD != '0),
      resultSrc:  bus.resultSrcD,
      memWrite:   bus.memWriteD,
      jump:       bus.jumpD,
      branch:     bus.branchD,
      ALUControl: bus.ALUControlD,
      ALUSrc:     bus.ALUSrcD,
      lui:        bus.luiD
   };

   assign data_d = {bus.RD1D, bus.RD2D, bus.extImmD, bus.PCD, bus.PCPlus4D,
                    bus.rs1D, bus.rs2D, bus.rdD};

   // Valid bit rides with the control bundle: any load that is not a bubble
   // is a real instruction.
   pipe_reg_en_clr #(.W(CTRL_W + 1)) u_ctrl_reg (
      .clk (clk),
      .rst (rst),
      .clr (bubble_load),
      .en  (bus.enE),
      .d   ({1'b1, ctrl_d}),
      .q   ({valid_q, ctrl_q})
   );

   pipe_reg_en_clr #(.W(DATA_W)) u_data_reg (
      .clk (clk),
      .rst (rst),
      .clr (bubble_load),
      .en  (bus.enE),
      .d   (data_d),
      .q   (data_q)
   );

   assign bus.validE      = valid_q;
   assign bus.regWriteE   = ctrl_q.regWrite;
   assign bus.resultSrcE  = ctrl_q.resultSrc;
   assign bus.memWriteE   = ctrl_q.memWrite;
   assign bus.jumpE       = ctrl_q.jump;
   assign bus.branchE     = ctrl_q.branch;
   assign bus.ALUControlE = ctrl_q.ALUControl;
   assign bus.ALUSrcE     = ctrl_q.ALUSrc;
   assign bus.luiE        = ctrl_q.lui;

   assign {bus.RD1E, bus.RD2E, bus.extImmE, bus.PCE, bus.PCPlus4E,
           bus.rs1E, bus.rs2E, bus.rdE} = data_q;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [CNT_W-1:0] bubble_cnt_reg;

   // Saturating count of bubbles loaded; stalls do not count.
   always_ff @(posedge clk) begin
      if (!rst)
         bubble_cnt_reg <= '0;
      else if (bubble_load && (bubble_cnt_reg != {CNT_W{1'b1}}))
         bubble_cnt_reg <= bubble_cnt_reg + CNT_W'(1);
   end

   assign bus.bubbleCntE = bubble_cnt_reg;
`else
   assign bus.bubbleCntE = '0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_pipe_reg
// Directed testbench for id_ex_pipe_reg (CNT_W=2 so saturation is reachable).
// -----------------------------------------------------------------------------
module tb_id_ex_pipe_reg;
   import riscv_pipe_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;
`ifdef ID_EX_BUBBLE_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic clk;
   logic rst;
   int   total;
   int   bad;

   id_ex_pipe_reg_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   id_ex_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_cnt(input string tag, input int v);
      logic [CNT_W-1:0] e;
      e = CNT_ON ? CNT_W'(v) : '0;
      chk(tag, 64'(bus.bubbleCntE), 64'(e));
   endtask

   function automatic logic any_out();
      return |{bus.validE, bus.regWriteE, bus.resultSrcE, bus.memWriteE,
               bus.jumpE, bus.branchE, bus.ALUControlE, bus.ALUSrcE, bus.luiE,
               bus.RD1E, bus.RD2E, bus.extImmE, bus.PCE, bus.PCPlus4E,
               bus.rs1E, bus.rs2E, bus.rdE, bus.bubbleCntE};
   endfunction

   task automatic set_all_ones();
      bus.validD = 1'b1; bus.regWriteD = 1'b1; bus.resultSrcD = '1;
      bus.memWriteD = 1'b1; bus.jumpD = '1; bus.branchD = '1;
      bus.ALUControlD = '1; bus.ALUSrcD = 1'b1; bus.luiD = 1'b1;
      bus.RD1D = '1; bus.RD2D = '1; bus.extImmD = '1; bus.PCD = '1;
      bus.PCPlus4D = '1; bus.rs1D = '1; bus.rs2D = '1; bus.rdD = '1;
   endtask

   initial begin
      total = 0;
      bad   = 0;

      // Reset for two cycles with every D input high.
      rst = 1'b0; bus.enE = 1'b1; bus.clrE = 1'b0;
      set_all_ones();
      step();
      step();
      chk("reset_any", 64'(any_out()), 64'd0);
      chk("reset_validE", 64'(bus.validE), 64'd0);
      chk("reset_cnt", 64'(bus.bubbleCntE), 64'd0);

      // First load right after release.
      rst = 1'b1;
      bus.validD = 1'b1; bus.regWriteD = 1'b1; bus.rdD = 5'd5;
      bus.RD1D = 32'h0000_1234; bus.ALUControlD = 3'b010;
      bus.RD2D = 32'h0000_CAFE; bus.extImmD = 32'h10; bus.PCD = 32'h80;
      bus.PCPlus4D = 32'h84; bus.rs1D = 5'd1; bus.rs2D = 5'd2;
      bus.resultSrcD = 2'b01; bus.memWriteD = 1'b0; bus.jumpD = 2'b00;
      bus.branchD = 3'b000; bus.ALUSrcD = 1'b1; bus.luiD = 1'b0;
      step();
      chk("load_regWriteE", 64'(bus.regWriteE), 64'd1);
      chk("load_rdE", 64'(bus.rdE), 64'd5);
      chk("load_RD1E", 64'(bus.RD1E), 64'h1234);
      chk("load_ALUControlE", 64'(bus.ALUControlE), 64'd2);
      chk("load_validE", 64'(bus.validE), 64'd1);
      chk("load_RD2E", 64'(bus.RD2E), 64'hCAFE);
      chk("load_PCPlus4E", 64'(bus.PCPlus4E), 64'h84);
      chk("load_rs2E", 64'(bus.rs2E), 64'd2);
      chk("load_resultSrcE", 64'(bus.resultSrcE), 64'd1);

      // Write to x0 is dropped; the rest loads.
      bus.rdD = 5'd0; bus.RD1D = 32'h0000_AAAA; bus.memWriteD = 1'b1;
      step();
      chk("x0_regWriteE", 64'(bus.regWriteE), 64'd0);
      chk("x0_memWriteE", 64'(bus.memWriteE), 64'd1);
      chk("x0_RD1E", 64'(bus.RD1E), 64'hAAAA);
      chk("x0_validE", 64'(bus.validE), 64'd1);

      // Stall holds contents for three cycles.
      bus.memWriteD = 1'b0; bus.rdD = 5'd3; bus.PCD = 32'h100;
      step();
      chk("stall_pre_PCE", 64'(bus.PCE), 64'h100);
      bus.enE = 1'b0; bus.PCD = 32'h104;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_PCE", 64'(bus.PCE), 64'h100);
         chk("stall_validE", 64'(bus.validE), 64'd1);
      end
      bus.enE = 1'b1;
      step();
      chk("stall_release_PCE", 64'(bus.PCE), 64'h104);
      chk_cnt("stall_cnt", 0);

      // Flush overrides stall.
      bus.enE = 1'b0; bus.clrE = 1'b1; bus.memWriteD = 1'b1; bus.rdD = 5'd7;
      step();
      chk("flush_memWriteE", 64'(bus.memWriteE), 64'd0);
      chk("flush_rdE", 64'(bus.rdE), 64'd0);
      chk("flush_validE", 64'(bus.validE), 64'd0);
      chk("flush_PCE", 64'(bus.PCE), 64'd0);
      chk_cnt("flush_cnt1", 1);

      // Four more flushes: counter saturates at 3.
      bus.enE = 1'b1;
      step(); chk_cnt("flush_cnt2", 2);
      step(); chk_cnt("flush_cnt3", 3);
      step(); chk_cnt("flush_cnt4", 3);
      step(); chk_cnt("flush_cnt5", 3);

      // Flush with X on data inputs yields clean zeros.
      bus.RD1D = 'x; bus.regWriteD = 1'bx;
      step();
      chk("flushx_RD1E", 64'(bus.RD1E), 64'd0);
      chk("flushx_regWriteE", 64'(bus.regWriteE), 64'd0);

      // Load with validD=0 is a bubble.
      bus.clrE = 1'b0; bus.validD = 1'b0; bus.regWriteD = 1'b1;
      bus.rdD = 5'd9; bus.RD1D = 32'h55;
      step();
      chk("invalid_validE", 64'(bus.validE), 64'd0);
      chk("invalid_rdE", 64'(bus.rdE), 64'd0);
      chk("invalid_regWriteE", 64'(bus.regWriteE), 64'd0);
      chk("invalid_RD1E", 64'(bus.RD1E), 64'd0);

      // Valid load, then reset during a stall empties the register.
      bus.validD = 1'b1;
      step();
      chk("reload_rdE", 64'(bus.rdE), 64'd9);
      chk("reload_validE", 64'(bus.validE), 64'd1);
      rst = 1'b0; bus.enE = 1'b0;
      step();
      chk("rststall_any", 64'(any_out()), 64'd0);

      // After reset the counter restarts from zero.
      rst = 1'b1; bus.clrE = 1'b1;
      step();
      chk_cnt("post_rst_cnt", 1);
      chk("post_rst_validE", 64'(bus.validE), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
